// File: rtl/fg_pixel_responder.sv
// fg_pixel_responder: fixed-latency foreground SRAM read pipeline with skip tags.
// Define FG_MISS_COUNT_EN to build the per-frame ungranted-request counter.
module fg_pixel_responder #(
  parameter int PIXEL_SIZE        = 16,
  parameter int PRECISION         = 11,
  parameter int RESOLUTION_X      = 800,
  parameter int RESOLUTION_Y      = 600,
  parameter int ADDR_WIDTH        = 19,
  parameter int SRAM_READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [PRECISION:0] req_x,
  input  logic signed [PRECISION:0] req_y,
  input  logic                    req_active,
  input  logic                    frame_start,
  input  logic                    sram_grant,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic                    sram_read_en,
  input  logic [PIXEL_SIZE-1:0]   sram_data,
  output logic [PIXEL_SIZE-1:0]   fg_pixel,
  output logic                    fg_pixel_skip,
  output logic [15:0]             miss_count
);

  localparam int TD = SRAM_READ_LATENCY + 1;
  localparam logic signed [PRECISION:0] RX =
    (PRECISION+1)'(RESOLUTION_X);
  localparam logic signed [PRECISION:0] RY =
    (PRECISION+1)'(RESOLUTION_Y);
  localparam logic [ADDR_WIDTH-1:0] RXA =
    ADDR_WIDTH'(RESOLUTION_X);

  logic                  in_frame;
  logic                  issue;
  logic [ADDR_WIDTH-1:0] lin_addr;
  logic [ADDR_WIDTH-1:0] addr_d, addr_q;
  logic                  ren_q;
  logic [TD-1:0]         tag_d, tag_q;
  logic [PIXEL_SIZE-1:0] pix_d, pix_q;
  logic                  skip_q;

  assign in_frame = req_active
                  & ~req_x[PRECISION] & (req_x < RX)
                  & ~req_y[PRECISION] & (req_y < RY);
  assign issue = in_frame & sram_grant;

  // Only meaningful when in_frame, so the sign bits can be dropped.
  assign lin_addr = ADDR_WIDTH'(req_y[PRECISION-1:0]) * RXA
                  + ADDR_WIDTH'(req_x[PRECISION-1:0]);

  assign addr_d = issue ? lin_addr : addr_q;
  assign pix_d  = tag_q[TD-1] ? sram_data : '0;

  always_comb begin
    tag_d    = '0;
    tag_d[0] = issue;
    for (int i = 1; i < TD; i++) tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      ren_q  <= 1'b0;
      tag_q  <= '0;
      pix_q  <= '0;
      skip_q <= 1'b1;
    end else begin
      addr_q <= addr_d;
      ren_q  <= issue;
      tag_q  <= tag_d;
      pix_q  <= pix_d;
      skip_q <= ~tag_q[TD-1];
    end
  end

  assign sram_addr     = addr_q;
  assign sram_read_en  = ren_q;
  assign fg_pixel      = pix_q;
  assign fg_pixel_skip = skip_q;

`ifdef FG_MISS_COUNT_EN
  logic        miss;
  logic [15:0] miss_d, miss_q;

  assign miss = in_frame & ~sram_grant;

  always_comb begin
    miss_d = miss_q;
    if (frame_start)
      miss_d = {15'd0, miss};
    else if (miss && miss_q != 16'hFFFF)
      miss_d = miss_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) miss_q <= '0;
    else     miss_q <= miss_d;
  end

  assign miss_count = miss_q;
`else
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_fg_pixel_responder.sv
// tb_fg_pixel_responder: directed + random checks against a queue-based model.
// Model SRAM returns a hash of the address (or a constant in const mode).
module tb_fg_pixel_responder;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [11:0] req_x = '0;
  logic signed [11:0] req_y = '0;
  logic               req_active = 1'b0;
  logic               frame_start = 1'b0;
  logic               sram_grant = 1'b0;
  logic [18:0]        sram_addr;
  logic               sram_read_en;
  logic [15:0]        sram_data = '0;
  logic [15:0]        fg_pixel;
  logic               fg_pixel_skip;
  logic [15:0]        miss_count;

  int checks = 0;
  int failures = 0;
  bit const_mode = 1'b0;

  always #5 clk = ~clk;

  fg_pixel_responder dut (
    .clk          (clk),
    .rst          (rst),
    .req_x        (req_x),
    .req_y        (req_y),
    .req_active   (req_active),
    .frame_start  (frame_start),
    .sram_grant   (sram_grant),
    .sram_addr    (sram_addr),
    .sram_read_en (sram_read_en),
    .sram_data    (sram_data),
    .fg_pixel     (fg_pixel),
    .fg_pixel_skip(fg_pixel_skip),
    .miss_count   (miss_count)
  );

  function automatic logic [15:0] memf(int a);
    if (const_mode) return 16'hF81F;
    return 16'((a * 40503) ^ (a >> 5) ^ 16'h5A3C);
  endfunction

  // SRAM with one edge of read latency; garbage when not reading.
  always @(posedge clk)
    sram_data <= sram_read_en ? memf(int'(sram_addr)) : 16'($urandom);

  // Reference: a response queue two deep (plus the output register).
  logic [16:0] q[$];
  logic [16:0] exp_out  = 17'h1;
  logic [18:0] exp_addr = '0;
  logic        exp_ren  = 1'b0;
  int          exp_miss = 0;

  always @(posedge clk) begin
    int x, y;
    bit inf;
    x   = int'(req_x);
    y   = int'(req_y);
    inf = req_active && x >= 0 && x < 800 && y >= 0 && y < 600;
    if (rst) begin
      q.delete();
      q.push_back(17'h1);
      q.push_back(17'h1);
      exp_out  = 17'h1;
      exp_addr = '0;
      exp_ren  = 1'b0;
      exp_miss = 0;
    end else begin
      exp_ren = inf && sram_grant;
      if (exp_ren) exp_addr = 19'(y * 800 + x);
      q.push_back(exp_ren ? {memf(y * 800 + x), 1'b0} : 17'h1);
      exp_out = q.pop_front();
`ifdef FG_MISS_COUNT_EN
      if (frame_start)
        exp_miss = (inf && !sram_grant) ? 1 : 0;
      else if (inf && !sram_grant && exp_miss < 65535)
        exp_miss++;
`endif
    end
  end

  wire [52:0] obs  = {fg_pixel, fg_pixel_skip, sram_read_en,
                      sram_addr, miss_count};
  wire [52:0] want = {exp_out, exp_ren, exp_addr, 16'(exp_miss)};

  task automatic drive(int x, int y, bit a, bit g,
                       bit fs = 1'b0, bit r = 1'b0);
    req_x       = 12'(x);
    req_y       = 12'(y);
    req_active  = a;
    sram_grant  = g;
    frame_start = fs;
    rst         = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) drive(5, 5, 1, 1, 1, 1);
    checks++;
    if ({sram_addr, sram_read_en, fg_pixel, fg_pixel_skip, miss_count}
        !== {19'd0, 1'b0, 16'd0, 1'b1, 16'd0}) begin
      failures++;
      $display("FAIL reset_values addr=%0d ren=%b pix=%h skip=%b miss=%0d",
               sram_addr, sram_read_en, fg_pixel, fg_pixel_skip, miss_count);
    end
  endtask

  task automatic test_basic;
    const_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < 5) drive(10, 2, 1, 1);
      else       drive(0, 0, 0, 0);
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL basic_model cyc=%0d got=%h want=%h", i, obs, want);
      end
      if (i == 0) begin
        checks++;
        if (sram_addr !== 19'd1610 || sram_read_en !== 1'b1) begin
          failures++;
          $display("FAIL basic_addr got=%0d/%b want=1610/1",
                   sram_addr, sram_read_en);
        end
      end
      if (i == 2) begin
        checks++;
        if (fg_pixel !== 16'hF81F || fg_pixel_skip !== 1'b0) begin
          failures++;
          $display("FAIL basic_pixel got=%h/%b want=f81f/0",
                   fg_pixel, fg_pixel_skip);
        end
      end
    end
    const_mode = 1'b0;
  endtask

  task automatic test_sweep;
    int xs[4]      = '{-1, 0, 799, 800};
    bit ex_skip[4] = '{1, 0, 0, 1};
    bit ex_ren[4]  = '{0, 1, 1, 0};
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive(xs[i], 0, 1, 1);
      else       drive(0, 0, 0, 1);
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL sweep_model cyc=%0d got=%h want=%h", i, obs, want);
      end
      if (i < 4) begin
        checks++;
        if (sram_read_en !== ex_ren[i] ||
            (ex_ren[i] && sram_addr !== 19'(xs[i]))) begin
          failures++;
          $display("FAIL sweep_issue x=%0d got=%b/%0d want=%b/%0d",
                   xs[i], sram_read_en, sram_addr, ex_ren[i], xs[i]);
        end
      end
      if (i >= 2 && i < 6) begin
        checks++;
        if (fg_pixel_skip !== ex_skip[i-2]) begin
          failures++;
          $display("FAIL sweep_skip x=%0d got=%b want=%b",
                   xs[i-2], fg_pixel_skip, ex_skip[i-2]);
        end
      end
    end
    drive(0, -1, 1, 1);
    drive(0, 600, 1, 1);
    drive(799, 599, 1, 1);
    checks++;
    if (sram_addr !== 19'd479999 || sram_read_en !== 1'b1) begin
      failures++;
      $display("FAIL corner_addr got=%0d/%b want=479999/1",
               sram_addr, sram_read_en);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1);
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL ybound_model cyc=%0d got=%h want=%h", i, obs, want);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) drive(i, 0, 1, 1);
      else       drive(0, 0, 0, 1);
      if (i >= 2 && i < 5) begin
        checks++;
        if (fg_pixel !== memf(i - 2) || fg_pixel_skip !== 1'b0) begin
          failures++;
          $display("FAIL b2b_pixel idx=%0d got=%h/%b want=%h/0",
                   i - 2, fg_pixel, fg_pixel_skip, memf(i - 2));
        end
      end
    end
  endtask

  task automatic test_inactive;
    for (int i = 0; i < 3; i++) begin
      drive(5, 5, i != 0 ? 1'b0 : 1'b0, 1);
      checks++;
      if (sram_read_en !== 1'b0) begin
        failures++;
        $display("FAIL inactive_ren cyc=%0d got=%b want=0", i, sram_read_en);
      end
    end
    checks++;
    if (fg_pixel !== 16'h0 || fg_pixel_skip !== 1'b1) begin
      failures++;
      $display("FAIL inactive_out got=%h/%b want=0000/1",
               fg_pixel, fg_pixel_skip);
    end
  endtask

  task automatic test_miss;
    logic [15:0] want4, want1;
`ifdef FG_MISS_COUNT_EN
    want4 = 16'd4;
    want1 = 16'd1;
`else
    want4 = 16'd0;
    want1 = 16'd0;
`endif
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(i + 1, 1, 1, 0);
    checks++;
    if (miss_count !== want4) begin
      failures++;
      $display("FAIL miss_four got=%0d want=%0d", miss_count, want4);
    end
    drive(7, 7, 1, 0, 1);
    checks++;
    if (miss_count !== want1) begin
      failures++;
      $display("FAIL miss_reload got=%0d want=%0d", miss_count, want1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0);
      checks++;
      if (obs !== want || fg_pixel_skip !== 1'b1) begin
        failures++;
        $display("FAIL miss_skip cyc=%0d got=%h want=%h", i, obs, want);
      end
    end
  endtask

  task automatic test_reset_midflight;
    drive(3, 3, 1, 1);
    drive(4, 3, 1, 1);
    drive(5, 3, 1, 1, 0, 1);
    checks++;
    if (sram_read_en !== 1'b0 || fg_pixel_skip !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_edge got=%b/%b want=0/1",
               sram_read_en, fg_pixel_skip);
    end
    for (int i = 0; i < 2; i++) begin
      drive(6 + i, 3, 1, 1);
      checks++;
      if (fg_pixel_skip !== 1'b1 || fg_pixel !== 16'h0) begin
        failures++;
        $display("FAIL rstmid_skip cyc=%0d got=%h/%b want=0000/1",
                 i, fg_pixel, fg_pixel_skip);
      end
    end
    drive(8, 3, 1, 1);
    checks++;
    if (fg_pixel !== memf(3 * 800 + 6) || fg_pixel_skip !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_resume got=%h/%b want=%h/0",
               fg_pixel, fg_pixel_skip, memf(3 * 800 + 6));
    end
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
  endtask

  task automatic test_random;
    int x, y, r;
    for (int i = 0; i < 2000; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      x = -2048 + int'($urandom_range(0, 100));
      else if (r == 1) x = 2047 - int'($urandom_range(0, 100));
      else             x = int'($urandom_range(0, 819)) - 10;
      r = int'($urandom_range(0, 9));
      if (r == 0)      y = -2048 + int'($urandom_range(0, 100));
      else if (r == 1) y = 2047 - int'($urandom_range(0, 100));
      else             y = int'($urandom_range(0, 619)) - 10;
      drive(x, y, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 49) == 0);
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL random_model cyc=%0d got=%h want=%h", i, obs, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_back_to_back();
    test_inactive();
    test_miss();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fg_pixel_responder.md
# fg_pixel_responder

Serves the foreground-pixel request interface of the compositing pipeline: it accepts a signed foreground coordinate plus an active flag every clock, translates it to a linear SRAM address, issues the read, and returns the pixel with a fixed request-to-response latency. Out-of-frame, inactive or ungranted requests return a skip flag instead of a pixel. It sits between the compositing pipeline and the foreground SRAM read port.

## Interface
- `PIXEL_SIZE`, 16, bits per pixel (RGB565).
- `PRECISION`, 11, coordinate magnitude width; request coordinates are signed `PRECISION+1` bits.
- `RESOLUTION_X`, 800, foreground frame width in pixels.
- `RESOLUTION_Y`, 600, foreground frame height in pixels.
- `ADDR_WIDTH`, 19, SRAM word address width; must hold `RESOLUTION_X*RESOLUTION_Y-1`.
- `SRAM_READ_LATENCY`, 1, edges from `sram_read_en`/`sram_addr` registered to `sram_data` valid; total latency = `SRAM_READ_LATENCY+2`.

- `clk` in 1: pixel clock, single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `req_x` in `PRECISION+1` signed: requested foreground x.
- `req_y` in `PRECISION+1` signed: requested foreground y.
- `req_active` in 1: request is meaningful this cycle.
- `frame_start` in 1: one-cycle pulse at start of each frame.
- `sram_grant` in 1: read port available this cycle (low while the frame writer owns SRAM).
- `sram_addr` out `ADDR_WIDTH`: registered read address.
- `sram_read_en` out 1: registered read strobe.
- `sram_data` in `PIXEL_SIZE`: read data, valid `SRAM_READ_LATENCY` edges after strobe.
- `fg_pixel` out `PIXEL_SIZE`: returned pixel, registered.
- `fg_pixel_skip` out 1: returned pixel is not valid, registered.
- `miss_count` out 16: ungranted in-frame requests this frame.

## Operation
- Stage 0 (comb): `in_frame = req_active & req_x>=0 & req_x<RESOLUTION_X & req_y>=0 & req_y<RESOLUTION_Y`; signed compares at full `PRECISION+1` width. `issue = in_frame & sram_grant`.
- Stage 1 (reg): `sram_addr <= y*RESOLUTION_X + x` truncated to `ADDR_WIDTH` when `issue`, else holds; `sram_read_en <= issue`. Tag bit `issue` enters a shift register of depth `SRAM_READ_LATENCY+1`.
- Stage 2..: tag travels with the read; data is not stored in-flight, only the tag.
- Output (reg): tag at pipe end =1 → `fg_pixel <= sram_data`, `fg_pixel_skip <= 0`; tag=0 → `fg_pixel <= 0`, `fg_pixel_skip <= 1`.
- Fully pipelined: one request accepted and one response produced every cycle; no backpressure, no stall.
- Miss counter: increments when `in_frame & ~sram_grant`; saturates at 16'hFFFF; `frame_start` reloads it to 0, or to 1 if a miss occurs the same cycle.

## Timing
- Request presented in cycle N → `fg_pixel`/`fg_pixel_skip` valid in cycle N+`SRAM_READ_LATENCY`+2 (3 at defaults), matching the consumer's fixed 3-cycle background delay.
- `sram_addr`/`sram_read_en` valid in cycle N+1.
- Reset values: `sram_addr`=0, `sram_read_en`=0, `fg_pixel`=0, `fg_pixel_skip`=1, `miss_count`=0, tag pipe all 0.
- Reset mid-operation: all in-flight tags cleared; the `SRAM_READ_LATENCY+2` responses after `rst` deasserts report skip regardless of `sram_data`.
- Boundaries: x=-1, y=-1, x=`RESOLUTION_X`, y=`RESOLUTION_Y` are skip; (0,0) → addr 0; (799,599) → addr 479999.
- `sram_grant` sampled only in the request cycle; a later drop does not cancel an issued read.

## Configuration
- `FG_MISS_COUNT_EN` defined: miss counter built as above.
- Undefined: counter logic omitted, `miss_count` tied to 0; all other behaviour identical.

## Test plan
- Reset then constant request (10,2), grant=1 → cycle 1 `sram_addr`=1610, `read_en`=1; cycle 3 `fg_pixel`=`sram_data` (drive 16'hF81F), skip=0.
- Sweep x = -1, 0, 799, 800 at y=0 → skip = 1,0,0,1 three cycles later; addr 0 and 799 issued only for in-frame points.
- Back-to-back requests (0,0),(1,0),(2,0) with model SRAM → three consecutive pixels returned in order, no gaps.
- `req_active`=0 at (5,5) → no `read_en`, skip=1, `fg_pixel`=0.
- With `FG_MISS_COUNT_EN`: 4 in-frame requests with grant=0 → skip=1 each, `miss_count`=4; `frame_start` coincident with a fifth miss → `miss_count`=1.
- Assert `rst` one cycle with two reads in flight → next 3 outputs skip=1, `read_en`=0 after reset edge.
